mod_buzz_sequencer: RTL and testbench
=====================================

Name: mod_buzz_sequencer

Overview:
- Upstream driver for mod_buzzer. Accepts beep requests (duration, gap, repeat count) over a valid/ready interface and buffers them in a small FIFO.
- Replays each request to the buzzer as trigger/period pulses. Handshakes on the buzzer's cyc output and enforces a millisecond-timed silent gap after every beep.
- Runs on the 1 MHz system clock. An internal 1 ms tick is derived from that clock.

Parameters:
- BUZ_PERIOD_MS, 3000: max beep duration in ms. PERIOD_W = $clog2(BUZ_PERIOD_MS)+1, matching the buzzer period input.
- GAP_MAX_MS, 1000: max gap in ms. GAP_W = $clog2(GAP_MAX_MS)+1.
- REP_W, 4: repeat-count width.
- FIFO_DEPTH, 4: request entries (power of two, ≥2).
- TICK_DIV, 1000: clocks per 1 ms tick.
- TRIG_TIMEOUT_MS, 4: ms to wait for buz_cyc_i after raising trigger.

Ports:
- clk_i_1MHz  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_dur_ms_i  in  PERIOD_W  beep duration
- req_gap_ms_i  in  GAP_W  silence after each beep
- req_count_i  in  REP_W  number of beeps
- abort_i  in  1  flush queued/pending beeps
- err_clr_i  in  1  clear err_o
- buz_trig_o  out  1  to buzzer trig_i
- buz_period_ms_o  out  PERIOD_W  to buzzer period_ms_i
- buz_cyc_i  in  1  from buzzer cyc_o
- busy_o  out  1  state≠IDLE or FIFO non-empty
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- err_o  out  1  sticky trigger-timeout flag

Behaviour:
- Reset (synchronous, while rst_i high):
  - State S_IDLE; FIFO empty; prescaler, gap, timeout and repeat counters 0.
  - Outputs: buz_trig_o=0, buz_period_ms_o=0, err_o=0, busy_o=0, level_o=0, req_ready_o=0.
  - rst_i mid-operation aborts everything; the buzzer is reset by its own rst_i.
- Tick: prescaler counts 0..TICK_DIV-1 and wraps. tick is a one-cycle pulse when the count equals TICK_DIV-1. The prescaler free-runs and is not resynchronised per request.
- FIFO:
  - req_ready_o = !full & !abort_i & !rst_i.
  - Push on valid&ready, storing {dur,gap,count}.
  - Pop only in S_LOAD. Push and pop in the same cycle leave level unchanged.
  - Full: ready=0, no overwrite.
- FSM:
  - S_IDLE: FIFO non-empty -> S_LOAD.
  - S_LOAD (1 cycle): pop head into dur/gap/rep registers; clear timeout counter. If count==0 -> S_IDLE, with no trigger issued. Otherwise -> S_TRIG.
  - S_TRIG:
    - buz_trig_o=1 and buz_period_ms_o=dur, held until buz_cyc_i=1. Timeout counter increments on tick.
    - buz_cyc_i=1 -> S_BUSY; trig drops the next cycle.
    - Timeout reaches TRIG_TIMEOUT_MS first -> err_o=1, current entry discarded, -> S_IDLE.
  - S_BUSY: buz_trig_o=0; buz_period_ms_o holds dur. When buz_cyc_i=0: rep<=rep-1, gap counter<=0, -> S_GAP.
  - S_GAP: gap counter increments on tick. When counter==gap: rep≠0 -> S_TRIG (timeout counter cleared), else -> S_IDLE. gap=0 exits the cycle after entry.
- dur=0 is legal: the buzzer completes an empty cycle, and the handshake proceeds normally.
- abort_i (one cycle suffices):
  - Flushes the FIFO (level 0 next cycle).
  - In S_LOAD, S_TRIG or S_GAP: -> S_IDLE and buz_trig_o=0 next cycle.
  - In S_BUSY: rep<=0, then wait for buz_cyc_i=0 and go directly to S_IDLE, skipping the gap. A beep already in progress cannot be cut short.
- Abort with a simultaneous push: abort wins and the push is not accepted (ready=0).
- err_o: sticky. err_clr_i clears it. Timeout and err_clr_i in the same cycle -> err_o=1.
- Widths: all counters are saturation-free by construction (gap ≤ GAP_MAX_MS). rep decrement never occurs at 0.

Test Plan:
- Push {dur=5,gap=3,count=2}; buzzer model raises cyc within 1 ms, holds 5 ms -> two trig assertions with period=5, each followed by ≥3 ticks of gap, then busy_o=0.
- Push 5 requests back-to-back with FIFO_DEPTH=4 and no pops -> ready=0 after the 4th, level_o=4, 5th not accepted.
- Buzzer model never raises cyc -> trig held exactly 4 ms of ticks, err_o=1, entry dropped, next queued entry proceeds. err_clr_i clears err_o.
- Push {count=0} then {dur=2,gap=0,count=1} -> first entry popped with no trig, second beeps once, IDLE the cycle after gap check.
- abort_i during S_GAP with 3 queued entries -> level_o=0 next cycle, S_IDLE, no further trig. abort_i during S_BUSY -> no gap, IDLE right after cyc falls.
- rst_i asserted during S_TRIG -> next cycle buz_trig_o=0, level_o=0, err_o=0, req_ready_o=1 after release.

Source files
------------

// File: rtl/mod_buzz_sequencer_if.sv
// Request channel into the buzz sequencer.
// Carries one beep pattern (duration, gap, repeat count) per valid/ready handshake.
interface mod_buzz_sequencer_if #(
   parameter int PERIOD_W = 13,
   parameter int GAP_W    = 11,
   parameter int REP_W    = 4
) ();

   logic                req_valid_i;
   logic                req_ready_o;
   logic [PERIOD_W-1:0] req_dur_ms_i;
   logic [GAP_W-1:0]    req_gap_ms_i;
   logic [REP_W-1:0]    req_count_i;

   // Upstream producer of beep requests
   modport master (
      output req_valid_i,
      output req_dur_ms_i,
      output req_gap_ms_i,
      output req_count_i,
      input  req_ready_o
   );

   // The sequencer consuming requests
   modport slave (
      input  req_valid_i,
      input  req_dur_ms_i,
      input  req_gap_ms_i,
      input  req_count_i,
      output req_ready_o
   );

endinterface

// File: rtl/mod_buzz_sequencer.sv
// Upstream driver for mod_buzzer.
// Queues beep requests in a small FIFO. Each request is replayed as trigger pulses to the
// buzzer. The sequencer handshakes on the buzzer's cyc output, and it times a silent gap
// after every beep using a 1 ms tick derived from the 1 MHz clock.
module mod_buzz_sequencer #(
   parameter  int BUZ_PERIOD_MS   = 3000,
   parameter  int GAP_MAX_MS      = 1000,
   parameter  int REP_W           = 4,
   parameter  int FIFO_DEPTH      = 4,
   parameter  int TICK_DIV        = 1000,
   parameter  int TRIG_TIMEOUT_MS = 4,
   localparam int PERIOD_W        = $clog2(BUZ_PERIOD_MS) + 1,
   localparam int GAP_W           = $clog2(GAP_MAX_MS) + 1,
   localparam int LEVEL_W         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk_i_1MHz,
   input  logic                 rst_i,
   mod_buzz_sequencer_if.slave  req,
   input  logic                 abort_i,
   input  logic                 err_clr_i,
   output logic                 buz_trig_o,
   output logic [PERIOD_W-1:0]  buz_period_ms_o,
   input  logic                 buz_cyc_i,
   output logic                 busy_o,
   output logic [LEVEL_W-1:0]   level_o,
   output logic                 err_o
);

   localparam int ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TMO_W   = $clog2(TRIG_TIMEOUT_MS) + 1;

   localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICK_DIV - 1);
   localparam logic [TMO_W-1:0]   TMO_MAX    = TMO_W'(TRIG_TIMEOUT_MS);
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_TRIG = 3'd2,
      S_BUSY = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   typedef struct packed {
      logic [PERIOD_W-1:0] dur;
      logic [GAP_W-1:0]    gap;
      logic [REP_W-1:0]    count;
   } entry_t;

   state_t              state_q;
   state_t              state_d;

   logic [PRESC_W-1:0]  presc_q;
   logic                tick;

   entry_t              fifo_mem_q [FIFO_DEPTH];
   logic [ADDR_W:0]     wr_ptr_q;
   logic [ADDR_W:0]     rd_ptr_q;
   logic [LEVEL_W-1:0]  fifo_level;
   logic                fifo_empty;
   logic                fifo_full;
   logic                fifo_push;
   logic                fifo_pop;
   entry_t              fifo_head;
   entry_t              fifo_wdata;

   logic [PERIOD_W-1:0] dur_q;
   logic [GAP_W-1:0]    gap_q;
   logic [REP_W-1:0]    rep_q;
   logic [GAP_W-1:0]    gap_cnt_q;
   logic [TMO_W-1:0]    tmo_cnt_q;
   logic                abort_pend_q;
   logic                err_q;
   logic                tmo_hit;

   // ------------------------------------------------------------------
   // Millisecond tick
   // ------------------------------------------------------------------
   assign tick = (presc_q == PRESC_MAX);

   // Free-running prescaler; never realigned to requests, so the first ms of a gap may be short
   always_ff @(posedge clk_i_1MHz) begin
      if (rst_i) begin
         presc_q <= '0;
      end else if (tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Request FIFO
   // ------------------------------------------------------------------
   assign fifo_level      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty      = (fifo_level == '0);
   assign fifo_full       = (fifo_level == LEVEL_FULL);
   assign req.req_ready_o = !fifo_full && !abort_i && !rst_i;
   assign fifo_push       = req.req_valid_i && req.req_ready_o;
   assign fifo_pop        = (state_q == S_LOAD);
   assign fifo_head       = fifo_mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign fifo_wdata      = '{dur:   req.req_dur_ms_i,
                              gap:   req.req_gap_ms_i,
                              count: req.req_count_i};

   // Pointer update; abort empties the queue by catching the read pointer up to the write pointer
   always_ff @(posedge clk_i_1MHz) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (abort_i) begin
         rd_ptr_q <= wr_ptr_q;
      end else begin
         if (fifo_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Entry storage; the array is not reset because only the pointers define its valid contents
   always_ff @(posedge clk_i_1MHz) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q[ADDR_W-1:0]] <= fifo_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------

   // State register
   always_ff @(posedge clk_i_1MHz) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins everywhere except BUSY, where the running beep must finish
   always_comb begin
      state_d = state_q;
      tmo_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty && !abort_i) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort_i || (fifo_head.count == '0)) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_TRIG;
            end
         end
         S_TRIG: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (buz_cyc_i) begin
               state_d = S_BUSY;
            end else if (tmo_cnt_q == TMO_MAX) begin
               tmo_hit = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_BUSY: begin
            if (!buz_cyc_i) begin
               state_d = (abort_pend_q || abort_i) ? S_IDLE : S_GAP;
            end
         end
         S_GAP: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (gap_cnt_q == gap_q) begin
               state_d = (rep_q != '0) ? S_TRIG : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic; the period is presented for as long as the buzzer may be using it
   always_comb begin
      buz_trig_o      = 1'b0;
      buz_period_ms_o = '0;
      case (state_q)
         S_TRIG: begin
            buz_trig_o      = 1'b1;
            buz_period_ms_o = dur_q;
         end
         S_BUSY: begin
            buz_period_ms_o = dur_q;
         end
         default: begin
            buz_trig_o      = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Per-request working registers
   // ------------------------------------------------------------------

   // Latches the popped entry and runs the repeat, gap and trigger-timeout counters
   always_ff @(posedge clk_i_1MHz) begin
      if (rst_i) begin
         dur_q        <= '0;
         gap_q        <= '0;
         rep_q        <= '0;
         gap_cnt_q    <= '0;
         tmo_cnt_q    <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               dur_q        <= fifo_head.dur;
               gap_q        <= fifo_head.gap;
               rep_q        <= fifo_head.count;
               tmo_cnt_q    <= '0;
               abort_pend_q <= 1'b0;
            end
            S_TRIG: begin
               if (tick && (tmo_cnt_q != TMO_MAX)) begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_BUSY: begin
               if (abort_i || abort_pend_q) begin
                  rep_q        <= '0;
                  abort_pend_q <= 1'b1;
               end else if (!buz_cyc_i) begin
                  rep_q     <= rep_q - 1'b1;
                  gap_cnt_q <= '0;
               end
            end
            S_GAP: begin
               if (tick) begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
               if (gap_cnt_q == gap_q) begin
                  tmo_cnt_q <= '0;
               end
            end
            default: begin
               abort_pend_q <= abort_pend_q;
            end
         endcase
      end
   end

   // Sticky trigger-timeout flag; a new timeout beats a simultaneous clear
   always_ff @(posedge clk_i_1MHz) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (tmo_hit) begin
         err_q <= 1'b1;
      end else if (err_clr_i) begin
         err_q <= 1'b0;
      end
   end

   assign err_o   = err_q;
   assign level_o = fifo_level;
   assign busy_o  = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mod_buzz_sequencer.sv
// Directed testbench for mod_buzz_sequencer with a simple behavioural buzzer model.
module tb_mod_buzz_sequencer;

   localparam int TD = 10;
   localparam int PW = 13;
   localparam int GW = 11;
   localparam int RW = 4;
   localparam int LW = 3;

   logic          clk;
   logic          rst;
   logic          abort;
   logic          err_clr;
   logic          buz_trig;
   logic [PW-1:0] buz_period;
   logic          buz_cyc;
   logic          busy;
   logic [LW-1:0] level;
   logic          err;

   int  checks = 0;
   int  errors = 0;

   int  tb_presc;
   logic tb_tick;
   int  rises = 0;
   int  trig_ticks = 0;
   logic trig_d = 1'b0;

   bit  bz_en;
   int  bz_cnt;
   int  bz_dly;

   mod_buzz_sequencer_if #(.PERIOD_W(PW), .GAP_W(GW), .REP_W(RW)) req_if ();

   mod_buzz_sequencer #(
      .BUZ_PERIOD_MS  (3000),
      .GAP_MAX_MS     (1000),
      .REP_W          (RW),
      .FIFO_DEPTH     (4),
      .TICK_DIV       (TD),
      .TRIG_TIMEOUT_MS(4)
   ) dut (
      .clk_i_1MHz     (clk),
      .rst_i          (rst),
      .req            (req_if),
      .abort_i        (abort),
      .err_clr_i      (err_clr),
      .buz_trig_o     (buz_trig),
      .buz_period_ms_o(buz_period),
      .buz_cyc_i      (buz_cyc),
      .busy_o         (busy),
      .level_o        (level),
      .err_o          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent 1 ms tick reference, same phase as a prescaler cleared by reset
   always @(posedge clk) begin
      if (rst) tb_presc <= 0;
      else     tb_presc <= (tb_presc == TD - 1) ? 0 : tb_presc + 1;
   end
   assign tb_tick = (tb_presc == TD - 1);

   // Counts trigger rising edges and ticks seen while the trigger is high
   always @(posedge clk) begin
      trig_d <= buz_trig;
      if (buz_trig && !trig_d) rises <= rises + 1;
      if (buz_trig && tb_tick) trig_ticks <= trig_ticks + 1;
   end

   // Buzzer model: answers a trigger after 3 clocks and holds cyc for period ms (min 1 clock)
   always @(posedge clk) begin
      if (rst) begin
         buz_cyc <= 1'b0;
         bz_cnt  <= 0;
         bz_dly  <= 0;
      end else if (buz_cyc) begin
         if (bz_cnt <= 1) buz_cyc <= 1'b0;
         else             bz_cnt  <= bz_cnt - 1;
      end else if (buz_trig && bz_en) begin
         if (bz_dly == 2) begin
            buz_cyc <= 1'b1;
            bz_cnt  <= (buz_period == '0) ? 1 : int'(buz_period) * TD;
            bz_dly  <= 0;
         end else begin
            bz_dly  <= bz_dly + 1;
         end
      end else begin
         bz_dly <= 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Presents one request for a cycle; must be called at a negedge
   task automatic applyStimulus(input int dur, input int gap, input int count, output bit accepted);
      req_if.req_dur_ms_i = PW'(dur);
      req_if.req_gap_ms_i = GW'(gap);
      req_if.req_count_i  = RW'(count);
      req_if.req_valid_i  = 1'b1;
      #1 accepted = req_if.req_ready_o;
      @(negedge clk);
      req_if.req_valid_i  = 1'b0;
   endtask

   function automatic logic sigSel(input int which);
      case (which)
         0:       return buz_trig;
         1:       return buz_cyc;
         default: return busy;
      endcase
   endfunction

   // Bounded wait for a signal level, counting reference ticks on the negedges before it
   task automatic waitSig(input string tag, input int which, input logic v, input int budget, output int ticks);
      bit done;
      done  = 1'b0;
      ticks = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (sigSel(which) == v) done = 1'b1;
         else if (tb_tick)       ticks++;
      end
      checkOutput({tag, "_reached"}, 32'(done), 1);
   endtask

   initial begin
      int  t;
      int  r0;
      int  k0;
      bit  acc;
      bit  acc_q [5];

      req_if.req_valid_i  = 1'b0;
      req_if.req_dur_ms_i = '0;
      req_if.req_gap_ms_i = '0;
      req_if.req_count_i  = '0;
      abort   = 1'b0;
      err_clr = 1'b0;
      bz_en   = 1'b0;
      rst     = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_trig",   32'(buz_trig), 0);
      checkOutput("rst_period", 32'(buz_period), 0);
      checkOutput("rst_err",    32'(err), 0);
      checkOutput("rst_busy",   32'(busy), 0);
      checkOutput("rst_level",  32'(level), 0);
      checkOutput("rst_ready",  32'(req_if.req_ready_o), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", 32'(req_if.req_ready_o), 1);

      // Two beeps of 5 ms with a 3 ms gap
      $display("[TB] basic two-beep request");
      bz_en = 1'b1;
      r0 = rises;
      applyStimulus(5, 3, 2, acc);
      checkOutput("b_accept", 32'(acc), 1);
      waitSig("b_trig1", 0, 1'b1, 200, t);
      checkOutput("b_period1", 32'(buz_period), 5);
      waitSig("b_cyc1_hi", 1, 1'b1, 200, t);
      waitSig("b_cyc1_lo", 1, 1'b0, 200, t);
      waitSig("b_trig2", 0, 1'b1, 200, t);
      checkOutput("b_gap1_ticks", 32'(t), 3);
      checkOutput("b_period2", 32'(buz_period), 5);
      waitSig("b_cyc2_hi", 1, 1'b1, 200, t);
      waitSig("b_cyc2_lo", 1, 1'b0, 200, t);
      waitSig("b_idle", 2, 1'b0, 200, t);
      checkOutput("b_gap2_ticks", 32'(t), 3);
      checkOutput("b_rises", 32'(rises - r0), 2);

      // Fill the FIFO while a long beep runs, then abort during BUSY
      $display("[TB] fifo fill and abort in busy");
      r0 = rises;
      applyStimulus(50, 2, 1, acc);
      waitSig("c_cyc_hi", 1, 1'b1, 100, t);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 1, 1, acc);
         acc_q[i] = acc;
      end
      checkOutput("c_accept4", 32'(acc_q[3]), 1);
      checkOutput("c_accept5", 32'(acc_q[4]), 0);
      checkOutput("c_level_full", 32'(level), 4);
      checkOutput("c_ready_full", 32'(req_if.req_ready_o), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("c_level_flush", 32'(level), 0);
      checkOutput("c_busy_in_beep", 32'(busy), 1);
      waitSig("c_cyc_lo", 1, 1'b0, 600, t);
      @(negedge clk);
      checkOutput("c_idle_no_gap", 32'(busy), 0);
      repeat (20) @(negedge clk);
      checkOutput("c_rises", 32'(rises - r0), 1);

      // Buzzer silent: trigger times out after 4 ticks, next entry still runs
      $display("[TB] trigger timeout");
      bz_en = 1'b0;
      r0 = rises;
      k0 = trig_ticks;
      checkOutput("d_err_before", 32'(err), 0);
      applyStimulus(7, 0, 1, acc);
      applyStimulus(3, 1, 1, acc);
      waitSig("d_trig1", 0, 1'b1, 50, t);
      checkOutput("d_period1", 32'(buz_period), 7);
      waitSig("d_trig1_drop", 0, 1'b0, 100, t);
      checkOutput("d_timeout_ticks", 32'(trig_ticks - k0), 4);
      checkOutput("d_err_set", 32'(err), 1);
      bz_en = 1'b1;
      waitSig("d_trig2", 0, 1'b1, 20, t);
      checkOutput("d_period2", 32'(buz_period), 3);
      waitSig("d_cyc_hi", 1, 1'b1, 50, t);
      waitSig("d_cyc_lo", 1, 1'b0, 100, t);
      waitSig("d_idle", 2, 1'b0, 100, t);
      checkOutput("d_err_sticky", 32'(err), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checkOutput("d_err_cleared", 32'(err), 0);
      checkOutput("d_rises", 32'(rises - r0), 2);

      // Zero-count entry is dropped silently; zero gap returns to idle right after the check
      $display("[TB] zero count and zero gap");
      r0 = rises;
      applyStimulus(9, 2, 0, acc);
      applyStimulus(2, 0, 1, acc);
      waitSig("e_trig", 0, 1'b1, 50, t);
      checkOutput("e_period", 32'(buz_period), 2);
      waitSig("e_cyc_hi", 1, 1'b1, 50, t);
      waitSig("e_cyc_lo", 1, 1'b0, 100, t);
      @(negedge clk);
      checkOutput("e_gap_cycle", 32'(busy), 1);
      @(negedge clk);
      checkOutput("e_idle", 32'(busy), 0);
      checkOutput("e_rises", 32'(rises - r0), 1);

      // Abort during a long gap with three entries queued, together with a push attempt
      $display("[TB] abort in gap");
      r0 = rises;
      applyStimulus(2, 20, 1, acc);
      waitSig("f_cyc_hi", 1, 1'b1, 50, t);
      waitSig("f_cyc_lo", 1, 1'b0, 100, t);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, acc);
      checkOutput("f_level3", 32'(level), 3);
      req_if.req_valid_i = 1'b1;
      abort = 1'b1;
      #1 checkOutput("f_ready_abort", 32'(req_if.req_ready_o), 0);
      @(negedge clk);
      req_if.req_valid_i = 1'b0;
      abort = 1'b0;
      checkOutput("f_level_flush", 32'(level), 0);
      checkOutput("f_idle", 32'(busy), 0);
      checkOutput("f_trig_low", 32'(buz_trig), 0);
      repeat (50) @(negedge clk);
      checkOutput("f_rises", 32'(rises - r0), 1);
      checkOutput("f_level_after", 32'(level), 0);

      // Reset while triggering, with an error pending and one entry queued
      $display("[TB] reset during trigger");
      bz_en = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(6, 1, 1, acc);
      waitSig("g_trig1", 0, 1'b1, 50, t);
      waitSig("g_trig1_drop", 0, 1'b0, 100, t);
      checkOutput("g_err_set", 32'(err), 1);
      waitSig("g_trig2", 0, 1'b1, 20, t);
      checkOutput("g_level1", 32'(level), 1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("g_trig", 32'(buz_trig), 0);
      checkOutput("g_level", 32'(level), 0);
      checkOutput("g_err", 32'(err), 0);
      checkOutput("g_ready_in_rst", 32'(req_if.req_ready_o), 0);
      checkOutput("g_busy", 32'(busy), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("g_ready_after", 32'(req_if.req_ready_o), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
